deadtime_gen: RTL and testbench

//  Multi-phase non-overlap / dead-time generator for the eBike inverter bridge.

---
 rtl/deadtime_gen.sv | 109 ++++++++++
 tb/tb_deadtime_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deadtime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : deadtime_gen
//  Description : Multi-phase non-overlap / dead-time generator. Each phase
//                blanks both gate drives for dead_time+1 cycles whenever its
//                high/low command changes. Simultaneous high+low requests are
//                treated as "off" and latch a sticky shoot-through fault.
//  Revision    : 1.0  initial release
// ============================================================================
module deadtime_gen #(
  parameter int NUM_PH = 3,
  parameter int DT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DT_W-1:0]   dead_time,
  input  logic [NUM_PH-1:0] high_in,
  input  logic [NUM_PH-1:0] low_in,
  input  logic              clr_fault,
  output logic [NUM_PH-1:0] high_out,
  output logic [NUM_PH-1:0] low_out,
  output logic [NUM_PH-1:0] in_dead,
  output logic              shoot_fault
);

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_H    = 2'd1,
    REQ_L    = 2'd2
  } req_t;

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [NUM_PH-1:0] w_pair_req;
  logic              shoot_fault_q;

  assign w_pair_req  = high_in & low_in;
  assign shoot_fault = shoot_fault_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PH; gi++) begin : g_ph
      req_t            req_d;
      req_t            req_q;
      state_t          state_q;
      logic [DT_W-1:0] cnt_q;
      logic            high_q;
      logic            low_q;

      // Decode the raw pin pair into a single request; a conflicting pair
      // is treated as "both off".
      always_comb begin
        req_d = REQ_NONE;
        if (high_in[gi] && !low_in[gi]) begin
          req_d = REQ_H;
        end else if (low_in[gi] && !high_in[gi]) begin
          req_d = REQ_L;
        end
      end

      // Per-phase blanking FSM: any change (or disable) reloads the dead-time
      // counter and kills both drives; drive resumes once the count expires.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          req_q   <= REQ_NONE;
          cnt_q   <= '1;
          state_q <= ST_DEAD;
          high_q  <= 1'b0;
          low_q   <= 1'b0;
        end else if (!en || (req_d != req_q)) begin
          high_q  <= 1'b0;
          low_q   <= 1'b0;
          state_q <= ST_DEAD;
          cnt_q   <= dead_time;
          req_q   <= req_d;
        end else if (state_q == ST_DEAD) begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DT_W'(1);
          end else begin
            state_q <= ST_DRIVE;
            high_q  <= (req_d == REQ_H);
            low_q   <= (req_d == REQ_L);
          end
        end
      end

      assign high_out[gi] = high_q;
      assign low_out[gi]  = low_q;
      assign in_dead[gi]  = (state_q == ST_DEAD);
    end
  endgenerate

  // Sticky shoot-through flag; a live conflicting request wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shoot_fault_q <= 1'b0;
    end else if (en && (|w_pair_req)) begin
      shoot_fault_q <= 1'b1;
    end else if (clr_fault) begin
      shoot_fault_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deadtime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deadtime_gen
//  Description : Self-checking bench for deadtime_gen. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a timestamp-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_deadtime_gen;

  localparam int NUM_PH = 3;
  localparam int DT_W   = 5;
  localparam int DT_MAX = (1 << DT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [DT_W-1:0]   dead_time;
  logic [NUM_PH-1:0] high_in;
  logic [NUM_PH-1:0] low_in;
  logic              clr_fault;
  logic [NUM_PH-1:0] high_out;
  logic [NUM_PH-1:0] low_out;
  logic [NUM_PH-1:0] in_dead;
  logic              shoot_fault;

  int checks = 0;
  int errors = 0;

  // Reference model state: per phase, the edge number of the most recent
  // change/disable, the dead time captured then, and the request in force.
  int                n_edge;
  int                evt_edge [NUM_PH];
  int                evt_dt   [NUM_PH];
  int                prev_req [NUM_PH];
  logic [NUM_PH-1:0] m_hi;
  logic [NUM_PH-1:0] m_lo;
  logic [NUM_PH-1:0] m_dead;
  logic              m_fault;

  deadtime_gen #(.NUM_PH(NUM_PH), .DT_W(DT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dead_time   (dead_time),
    .high_in     (high_in),
    .low_in      (low_in),
    .clr_fault   (clr_fault),
    .high_out    (high_out),
    .low_out     (low_out),
    .in_dead     (in_dead),
    .shoot_fault (shoot_fault)
  );

  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = none, 1 = high, 2 = low
  function automatic int req_of(input logic hi, input logic lo);
    if (hi && !lo) return 1;
    if (lo && !hi) return 2;
    return 0;
  endfunction

  // Power-up equals a "change" at edge 0 with the maximum dead time.
  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < NUM_PH; i++) begin
      evt_edge[i] = 0;
      evt_dt[i]   = DT_MAX;
      prev_req[i] = 0;
    end
    m_hi    = '0;
    m_lo    = '0;
    m_dead  = '1;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int r;
    n_edge++;
    for (int i = 0; i < NUM_PH; i++) begin
      r = req_of(high_in[i], low_in[i]);
      if (!en || r != prev_req[i]) begin
        evt_edge[i] = n_edge;
        evt_dt[i]   = int'(dead_time);
        prev_req[i] = r;
        m_hi[i]     = 1'b0;
        m_lo[i]     = 1'b0;
        m_dead[i]   = 1'b1;
      end else if (n_edge >= evt_edge[i] + evt_dt[i] + 1) begin
        m_hi[i]   = (r == 1);
        m_lo[i]   = (r == 2);
        m_dead[i] = 1'b0;
      end
    end
    if (en && |(high_in & low_in)) m_fault = 1'b1;
    else if (clr_fault)            m_fault = 1'b0;
  endtask

  // One clock: advance model, then compare every output away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("high_out",    32'(high_out),    32'(m_hi));
    check("low_out",     32'(low_out),     32'(m_lo));
    check("in_dead",     32'(in_dead),     32'(m_dead));
    check("shoot_fault", 32'(shoot_fault), 32'(m_fault));
    check("no_overlap",  32'(high_out & low_out), 32'd0);
  endtask

  initial begin
    int gap;
    int p;
    rst_n     = 1'b0;
    en        = 1'b0;
    dead_time = '0;
    high_in   = '0;
    low_in    = '0;
    clr_fault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_high",  32'(high_out),    32'd0);
    check("rst_low",   32'(low_out),     32'd0);
    check("rst_dead",  32'(in_dead),     32'h7);
    check("rst_fault", 32'(shoot_fault), 32'd0);

    // 1: power-up with high_in[0] held, dead_time 4 -> drive at edge 6
    @(negedge clk);
    rst_n     = 1'b1;
    en        = 1'b1;
    dead_time = 5'd4;
    high_in   = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t1_high0", 32'(high_out[0]), 32'(k == 6));
      check("t1_dead0", 32'(in_dead[0]),  32'(k < 6));
    end

    // 2: H -> L with dead_time 4: high drops at E0, low rises at E0+5
    high_in = 3'b000;
    low_in  = 3'b001;
    for (int k = 0; k <= 5; k++) begin
      step();
      check("t2_high0", 32'(high_out[0]), 32'd0);
      check("t2_low0",  32'(low_out[0]),  32'(k == 5));
    end

    // 3: gap length for dead_time 0 and dead_time 31
    dead_time = 5'd0;
    high_in   = 3'b001;
    low_in    = 3'b000;
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (high_out[0]) break;
      gap++;
    end
    check("t3_gap_dt0", 32'(gap), 32'd1);
    dead_time = 5'd31;
    high_in   = 3'b000;
    low_in    = 3'b001;
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (low_out[0]) break;
      gap++;
    end
    check("t3_gap_dt31", 32'(gap), 32'd32);

    // 4: glitch L -> H -> L... here: drive H, go to L, back to H at E0+2
    dead_time = 5'd4;
    high_in   = 3'b001;
    low_in    = 3'b000;
    repeat (6) step();
    check("t4_pre_high0", 32'(high_out[0]), 32'd1);
    high_in = 3'b000;
    low_in  = 3'b001;
    step();  // E0
    step();  // E0+1
    high_in = 3'b001;
    low_in  = 3'b000;
    for (int k = 2; k <= 7; k++) begin
      step();
      check("t4_low0",  32'(low_out[0]),  32'd0);
      check("t4_high0", 32'(high_out[0]), 32'(k == 7));
    end

    // 5: shoot-through request on phase 1, phase 2 driving low
    low_in = 3'b100;
    repeat (6) step();
    high_in = 3'b011;
    low_in  = 3'b110;
    step();
    check("t5_fault_set", 32'(shoot_fault), 32'd1);
    check("t5_ph1_off",   32'({high_out[1], low_out[1]}), 32'd0);
    check("t5_ph0_hi",    32'(high_out[0]), 32'd1);
    clr_fault = 1'b1;
    step();
    check("t5_fault_hold", 32'(shoot_fault), 32'd1);
    clr_fault = 1'b0;
    high_in   = 3'b001;
    low_in    = 3'b100;
    step();
    check("t5_fault_sticky", 32'(shoot_fault), 32'd1);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    check("t5_fault_clr", 32'(shoot_fault), 32'd0);
    check("t5_ph2_lo",    32'(low_out[2]),  32'd1);

    // 6: disable while driving, then re-enable with dead_time 3
    dead_time = 5'd3;
    repeat (6) step();
    en = 1'b0;
    step();
    check("t6_off_hi", 32'(high_out), 32'd0);
    check("t6_off_lo", 32'(low_out),  32'd0);
    step();
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t6_ret_hi0", 32'(high_out[0]), 32'(k == 4));
      check("t6_ret_lo2", 32'(low_out[2]),  32'(k == 4));
    end

    // Asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_high",  32'(high_out),    32'd0);
    check("arst_low",   32'(low_out),     32'd0);
    check("arst_dead",  32'(in_dead),     32'h7);
    check("arst_fault", 32'(shoot_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int s = 0; s < 2000; s++) begin
      for (int i = 0; i < NUM_PH; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          p = (($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)));
          high_in[i] = (p == 1) || (p == 3);
          low_in[i]  = (p == 2) || (p == 3);
        end
      end
      if ($urandom_range(0, 9) == 0)
        dead_time = ($urandom_range(0, 7) == 0) ? DT_W'($urandom_range(0, DT_MAX))
                                                : DT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr_fault = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
